// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_pkg
// Description : Shared definitions for the programmable sequence detector:
//               pattern-length width helper, default sync word and its
//               length, and the detection-mode encoding.
// Revision    : 1.0  initial release
// ============================================================================
package seq_detect_pkg;

    // Width needed to hold a length value in the range 0..pat_w.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam logic [4:0] SYNC_WORD = 5'b11001;
    localparam int         SYNC_LEN  = 5;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

endpackage : seq_detect_pkg
`default_nettype wire

// File: rtl/seq_hist_shreg.sv
`default_nettype none
// ============================================================================
// Module      : seq_hist_shreg
// Description : History shift register of past stream bits (newest at bit 0)
//               with a saturating count of how many history bits are valid.
//               Clear has priority over shift.
// Ports       : clk, rst_n   clock / async active-low reset
//               clr          drop all history (fill -> 0)
//               shift        append in_bit to history
//               in_bit       bit to append
//               history      PAT_W-1 past bits, newest at bit 0
//               fill         valid history bits, saturates at PAT_W-1
// Revision    : 1.0  initial release
// ============================================================================
module seq_hist_shreg
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      shift,
    input  logic                      in_bit,
    output logic [PAT_W-2:0]          history,
    output logic [$clog2(PAT_W)-1:0]  fill
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0] hist_shifted;

    // A two-bit maximum pattern leaves a one-bit history with nothing to
    // slice, so that case is built separately.
    generate
        if (PAT_W == 2) begin : g_hist_one
            assign hist_shifted = in_bit;
        end else begin : g_hist_multi
            assign hist_shifted = {history[PAT_W-3:0], in_bit};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= '0;
            fill    <= '0;
        end else if (clr) begin
            history <= '0;
            fill    <= '0;
        end else if (shift) begin
            history <= hist_shifted;
            if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

endmodule : seq_hist_shreg
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_prog
// Description : Runtime-programmable serial pattern detector (1..PAT_W bits)
//               with overlapping / non-overlapping detection, a Mealy match
//               flag and a registered copy.
// Ports       : clk, rst_n      clock / async active-low reset
//               in_valid, in_bit qualified serial stream
//               mode_overlap     1 = overlapping, 0 = non-overlapping
//               cfg_load         pulse: load cfg_pattern / cfg_len
//               cfg_pattern      pattern, bit len-1 is received first
//               cfg_len          pattern length (1..PAT_W legal)
//               match            combinational match flag
//               match_q          match delayed one cycle
//               cfg_err          pulse: last cfg_load had an illegal length
//               active_len       programmed length
//               match_cnt        saturating match count (SEQDET_MATCH_CNT_EN)
// Options     : define SEQDET_MATCH_CNT_EN to build the match counter.
// Revision    : 1.0  initial release
// ============================================================================
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(SYNC_WORD),
    parameter int               DEF_LEN     = SYNC_LEN,
    parameter int               CNT_W       = 16,
    localparam int              LEN_W       = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             mode_overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             match,
    output logic             match_q,
    output logic             cfg_err,
`ifdef SEQDET_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic [LEN_W-1:0] active_len
);

    localparam int FILL_W = $clog2(PAT_W);

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-2:0]  history;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window;
    logic [PAT_W-1:0]  len_mask;
    logic              fill_ok;
    logic              pat_ok;
    logic              len_ok;
    logic              overlap_now;
    logic              hist_clr;
    logic              hist_shift;
    mode_e             mode;

    assign mode        = mode_e'(mode_overlap);
    assign overlap_now = (mode == MODE_OVL);

    // Candidate sequence: stored history followed by the bit arriving now.
    assign window = {history, in_bit};

    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(active_len));
        end
    end

    // Need active_len-1 bits of history plus the current bit.
    assign fill_ok = (LEN_W'(fill) + LEN_W'(1)) >= active_len;
    assign pat_ok  = ((window ^ pattern) & len_mask) == '0;

    // Gated by rst_n so the flag is quiet throughout reset regardless of the
    // default configuration.
    assign match = rst_n & in_valid & ~cfg_load & fill_ok & pat_ok;

    // A non-overlapping hit consumes its bits: history restarts empty.
    assign hist_clr   = cfg_load | (match & ~overlap_now);
    assign hist_shift = in_valid & ~cfg_load & (~match | overlap_now);

    seq_hist_shreg #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (hist_clr),
        .shift   (hist_shift),
        .in_bit  (in_bit),
        .history (history),
        .fill    (fill)
    );

    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern    <= DEF_PATTERN;
            active_len <= LEN_W'(DEF_LEN);
            cfg_err    <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            match_q <= match;
            cfg_err <= cfg_load & ~len_ok;
            if (cfg_load && len_ok) begin
                pattern    <= cfg_pattern;
                active_len <= cfg_len;
            end
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
        end else if (cfg_load) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    // The counter width stays in the parameter list so both builds share one
    // instantiation; it has no consumer here.
    logic [CNT_W-1:0] cnt_width_unused;
    assign cnt_width_unused = '0;
`endif

endmodule : seq_detect_prog
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_prog
// Description : Scoreboard bench for seq_detect_prog. The driver applies one
//               cycle of stimulus, runs a bit-list reference model and queues
//               the expected outputs; the monitor pops and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_detect_prog;

    localparam int PAT_W   = 8;
    localparam int LEN_W   = $clog2(PAT_W + 1);
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [PAT_W-1:0] DEF_PAT = 8'b0001_1001;
    localparam int DEF_LEN = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             mode_overlap = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             match;
    logic             match_q;
    logic             cfg_err;
    logic [LEN_W-1:0] active_len;
`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    seq_detect_prog #(
        .PAT_W       (PAT_W),
        .DEF_PATTERN (DEF_PAT),
        .DEF_LEN     (DEF_LEN),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_bit       (in_bit),
        .mode_overlap (mode_overlap),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .match        (match),
        .match_q      (match_q),
        .cfg_err      (cfg_err),
`ifdef SEQDET_MATCH_CNT_EN
        .match_cnt    (match_cnt),
`endif
        .active_len   (active_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit m;
        bit q;
        bit err;
        int len;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the bits seen since the last clear, oldest first.
    bit               m_bits[$];
    logic [PAT_W-1:0] m_pat;
    int               m_len;
    bit               m_prev_match;
    bit               m_prev_err;
    int               m_cnt;

    task automatic model_reset();
        m_bits.delete();
        m_pat        = DEF_PAT;
        m_len        = DEF_LEN;
        m_prev_match = 1'b0;
        m_prev_err   = 1'b0;
        m_cnt        = 0;
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit o,
                        input bit ld, input logic [PAT_W-1:0] p, input int l);
        exp_t e;
        bit   m;
        bit   legal;
        @(posedge clk);
        #1;
        rst_n        = r;
        in_valid     = v;
        in_bit       = b;
        mode_overlap = o;
        cfg_load     = ld;
        cfg_pattern  = p;
        cfg_len      = LEN_W'(l);
        if (!r) begin
            model_reset();
            e.m = 0; e.q = 0; e.err = 0; e.len = DEF_LEN; e.cnt = 0;
            sb.push_back(e);
            return;
        end
        e.q   = m_prev_match;
        e.err = m_prev_err;
        e.len = m_len;
        e.cnt = m_cnt;
        // Newest m_len bits (current bit first) must equal pattern bits 0..len-1.
        m = 1'b0;
        if (v && !ld && m_bits.size() >= m_len - 1) begin
            m = 1'b1;
            for (int k = 0; k < m_len; k++) begin
                bit got;
                got = (k == 0) ? b : m_bits[m_bits.size() - k];
                if (got != m_pat[k]) m = 1'b0;
            end
        end
        e.m = m;
        sb.push_back(e);
        if (ld) begin
            legal = (l >= 1) && (l <= PAT_W);
            m_bits.delete();
            if (legal) begin
                m_pat = p;
                m_len = l;
            end
            m_prev_err = !legal;
            m_cnt      = 0;
        end else begin
            m_prev_err = 1'b0;
            if (v) begin
                if (m && !o) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(b);
                    if (m_bits.size() > PAT_W - 1) void'(m_bits.pop_front());
                end
            end
            if (m && m_cnt < CNT_MAX) m_cnt++;
        end
        m_prev_match = m;
    endtask

    task automatic send(input bit b, input bit o);
        step(1, 1, b, o, 0, '0, 0);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int l);
        step(1, 0, 0, 0, 1, p, l);
    endtask

    task automatic send_word(input logic [7:0] w, input int n, input bit o);
        for (int i = n - 1; i >= 0; i--) send(w[i], o);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the queued expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("match",      32'(match),      32'(e.m));
                chk("match_q",    32'(match_q),    32'(e.q));
                chk("cfg_err",    32'(cfg_err),    32'(e.err));
                chk("active_len", 32'(active_len), 32'(e.len));
`ifdef SEQDET_MATCH_CNT_EN
                chk("match_cnt",  32'(match_cnt),  32'(e.cnt));
`endif
            end
        end
    end

    // Driver
    initial begin
        model_reset();
        step(0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, '0, 0);

        // Default sync word, then trailing idles to see match_q.
        send_word(8'b11001, 5, 0);
        idle();
        idle();

        // 101, overlapping then non-overlapping.
        load(8'b101, 3);
        send_word(8'b10101, 5, 1);
        load(8'b101, 3);
        send_word(8'b10101, 5, 0);

        // Back to defaults with valid gaps.
        load(8'b11001, 5);
        send(1, 0); send(1, 0);
        idle(); idle(); idle();
        send(0, 0); send(0, 0); send(1, 0);

        // Illegal lengths leave the config but clear history.
        send_word(8'b1100, 4, 0);
        load(8'hFF, 0);
        send(1, 0);
        load(8'hFF, PAT_W + 1);
        idle();
        send_word(8'b11001, 5, 0);

        // Reset mid-stream.
        send_word(8'b1100, 4, 0);
        step(0, 0, 0, 0, 0, '0, 0);
        step(0, 0, 0, 0, 0, '0, 0);
        send(1, 0);
        send_word(8'b11001, 5, 0);

        // Single-bit pattern, overlapping: counter saturation, then clear.
        load(8'b1, 1);
        for (int i = 0; i < 6; i++) send(1, 1);
        load(8'b1, 1);
        idle();

        // Full-width pattern.
        load(8'b1011_0010, PAT_W);
        send_word(8'b1011_0010, 8, 1);
        send_word(8'b1011_0010, 8, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                step(0, 0, 0, 0, 0, '0, 0);
            end else if ($urandom_range(0, 49) == 0) begin
                int l;
                l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(1, 4));
                step(1, $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1), 1, PAT_W'($urandom), l);
            end else begin
                step(1, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                     $urandom_range(0, 1), 0, '0, 0);
            end
        end
        idle();

        repeat (3) @(posedge clk);
        #4;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_seq_detect_prog
`default_nettype wire

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Parametrised successor to the fixed 5-bit Mealy sequence detector.
- Detects a runtime-programmable serial bit pattern of 1..PAT_W bits on a qualified bit stream.
- Supports overlapping or non-overlapping detection.
- Gives a combinational Mealy match flag plus a registered copy. Sits on serial framing/sync-word paths.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2).
- DEF_PATTERN, 8'b0001_1001, pattern loaded at reset (low DEF_LEN bits used).
- DEF_LEN, 5, pattern length loaded at reset (1..PAT_W).
- CNT_W, 16, match counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_bit is a new stream bit this cycle.
- in_bit  in  1  serial data bit.
- mode_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_load  in  1  one-cycle pulse; load cfg_pattern/cfg_len.
- cfg_pattern  in  PAT_W  new pattern; bit len-1 is the first bit received.
- cfg_len  in  LEN_W=$clog2(PAT_W+1)  new pattern length.
- match  out  1  Mealy match, combinational from state and in_bit.
- match_q  out  1  match registered one cycle.
- cfg_err  out  1  registered pulse: cfg_load carried an illegal length.
- active_len  out  LEN_W  currently programmed length.
- match_cnt  out  CNT_W  saturating match count (only with the macro).

Behaviour:
- Reset (rst_n=0, async):
  - history=0, fill=0, pattern=DEF_PATTERN, active_len=DEF_LEN.
  - match_q=0, cfg_err=0, match_cnt=0.
  - match=0 while in reset.
- State: history (PAT_W-1 bit shift register of past bits, newest at bit 0) and fill (count of valid history bits, saturates at PAT_W-1).
- match = in_valid & ~cfg_load & (fill >= active_len-1) & ({history[active_len-2:0], in_bit} == pattern[active_len-1:0]).
  - For active_len=1: match = in_valid & ~cfg_load & (in_bit == pattern[0]).
- Sample (in_valid=1, cfg_load=0, match=0, or match=1 with mode_overlap=1):
  - history <= {history[PAT_W-3:0], in_bit}.
  - fill <= min(fill+1, PAT_W-1).
- Non-overlap match (match=1, mode_overlap=0): history <= 0, fill <= 0. The matching bit is not reused.
- in_valid=0: state holds, match=0.
- cfg_load with 1 <= cfg_len <= PAT_W:
  - pattern <= cfg_pattern, active_len <= cfg_len.
  - history and fill cleared.
  - cfg_err <= 0.
- cfg_load with cfg_len=0 or cfg_len>PAT_W:
  - Config unchanged, history/fill still cleared.
  - cfg_err <= 1 for one cycle.
- cfg_load concurrent with in_valid: load wins, bit discarded, match=0.
- match_q <= match every cycle.
- mode_overlap may change any cycle; it applies to the current cycle's match.
- Reset mid-stream: all partial-match progress is lost immediately.

Optional Feature:
- Macro SEQDET_MATCH_CNT_EN.
- Defined:
  - match_cnt increments on each cycle with match=1 and saturates at 2^CNT_W-1.
  - cfg_load (legal or illegal) clears it.
  - Reset value 0.
- Undefined: match_cnt port and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package seq_detect_pkg holds:
  - the LEN_W computation function;
  - the default sync-word constant (5'b11001) and its length;
  - an enum for mode (MODE_NONOVL=0, MODE_OVL=1).
- One natural sub-module: seq_hist_shreg (history shift register plus fill counter with clear and saturate). The compare, config and counter logic stay in the top module.

Test Plan:
- Defaults (11001, len 5), stream 1,1,0,0,1 -> match=1 only on the 5th valid bit; match_q=1 on the following cycle.
- Load 101 len 3, mode_overlap=1, stream 1,0,1,0,1 -> match on bits 3 and 5. Same stream with mode_overlap=0 -> match on bit 3 only.
- Stream 1,1 (in_valid gap of 3 cycles) 0,0,1 -> match on the final bit. During the gaps match=0 and state holds.
- cfg_load with cfg_len=0, then with cfg_len=PAT_W+1 -> cfg_err pulses each time, active_len stays 5, history cleared. The next full 11001 stream still matches.
- Assert rst_n low after 1,1,0,0, release, then drive 1 -> no match. A full 11001 afterwards matches.
- With SEQDET_MATCH_CNT_EN, CNT_W=2, six overlapping matches of pattern 1 len 1 -> match_cnt = 1,2,3,3,3,3. A subsequent cfg_load -> 0.
